halt_ctrl: RTL and testbench

- Drives the SoC-level `halt` and `firstWord` observables that the simulation harness samples.
- On a halt request from the core decode stage it:
  - stalls the core;
  - drains any in-flight memory access;
  - reads the word at FIRST_ADDR through a req/ack memory port;
  - latches that word and asserts `halt` permanently.
- Also maintains a free-running cycle counter and a sticky watchdog flag.
- Sits in `dut_soc` between the core, the memory arbiter and the top-level outputs.

---
 rtl/halt_pkg.sv | 14 +
 rtl/sat_counter.sv | 19 +
 rtl/halt_ctrl.sv | 87 ++++++++
 tb/tb_halt_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/halt_pkg.sv
// rtl/halt_pkg.sv - shared types and constants for the halt controller
package halt_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      READ   = 2'd2,
      HALTED = 2'd3
   } halt_state_t;

   localparam int WORD_W = 16;
   localparam logic [WORD_W-1:0] DEFAULT_FIRST_ADDR = 16'h0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - up counter with enable and sync clear that sticks at all-ones
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (clr) begin
         cnt <= '0;
      end else if (en && (cnt != '1)) begin
         cnt <= cnt + W'(1);
      end
   end

endmodule

// File: rtl/halt_ctrl.sv
// rtl/halt_ctrl.sv - stalls the core on HLT, drains memory, reads the report word and halts
module halt_ctrl
   import halt_pkg::*;
#(
   parameter logic [WORD_W-1:0] FIRST_ADDR = DEFAULT_FIRST_ADDR,
   parameter int unsigned       MAX_CYCLES = 500,
   parameter int                CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              haltReq,
   input  logic              memBusy,
   input  logic              memAck,
   input  logic [WORD_W-1:0] memData,
   output logic              memReq,
   output logic [WORD_W-1:0] memAddr,
   output logic              coreStall,
   output logic              halt,
   output logic [WORD_W-1:0] firstWord,
   output logic [CNT_W-1:0]  cycleCnt,
   output logic              timeout
);

   halt_state_t state;
   logic        ackTaken;
   logic        cntEn;
   logic        wdHit;
   logic [63:0] cntWide;

   // The edge that accepts the ack is the edge that enters HALTED, so the
   // counter must already be frozen on it and the watchdog must yield.
   assign ackTaken = (state == READ) && memAck;
   assign cntEn    = (state != HALTED) && !ackTaken;
   assign cntWide  = 64'(cycleCnt);
   assign wdHit    = (MAX_CYCLES != 0) && (cntWide == 64'(MAX_CYCLES));

   sat_counter #(
      .W(CNT_W)
   ) cycleCounter (
      .clk(clk),
      .clr(rst),
      .en (cntEn),
      .cnt(cycleCnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RUN;
         coreStall <= 1'b0;
         memReq    <= 1'b0;
         memAddr   <= FIRST_ADDR;
         halt      <= 1'b0;
         firstWord <= '0;
         timeout   <= 1'b0;
      end else begin
         memAddr <= FIRST_ADDR;
         if (wdHit && cntEn) begin
            timeout <= 1'b1;
         end
         case (state)
            RUN: begin
               if (haltReq) begin
                  state     <= DRAIN;
                  coreStall <= 1'b1;
               end
            end
            DRAIN: begin
               if (!memBusy) begin
                  state  <= READ;
                  memReq <= 1'b1;
               end
            end
            READ: begin
               if (memAck) begin
                  state     <= HALTED;
                  memReq    <= 1'b0;
                  halt      <= 1'b1;
                  firstWord <= memData;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_halt_ctrl.sv
// tb/tb_halt_ctrl.sv - bench for halt_ctrl: default, short-watchdog and 4-bit-counter instances
module tb_halt_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b0;
   logic        haltReq = 1'b0;
   logic        memBusy = 1'b0;
   logic        memAck = 1'b0;
   logic [15:0] memData = 16'h0000;

   logic [2:0]       memReqV, coreStallV, haltV, timeoutV;
   logic [2:0][15:0] memAddrV, firstWordV;
   logic [31:0]      cntA, cntW;
   logic [3:0]       cntS;
   longint           cntV [3];

   halt_ctrl dutA (
      .clk(clk), .rst(rst), .haltReq(haltReq), .memBusy(memBusy), .memAck(memAck),
      .memData(memData), .memReq(memReqV[0]), .memAddr(memAddrV[0]),
      .coreStall(coreStallV[0]), .halt(haltV[0]), .firstWord(firstWordV[0]),
      .cycleCnt(cntA), .timeout(timeoutV[0])
   );

   halt_ctrl #(.MAX_CYCLES(20)) dutW (
      .clk(clk), .rst(rst), .haltReq(haltReq), .memBusy(memBusy), .memAck(memAck),
      .memData(memData), .memReq(memReqV[1]), .memAddr(memAddrV[1]),
      .coreStall(coreStallV[1]), .halt(haltV[1]), .firstWord(firstWordV[1]),
      .cycleCnt(cntW), .timeout(timeoutV[1])
   );

   halt_ctrl #(.CNT_W(4)) dutS (
      .clk(clk), .rst(rst), .haltReq(haltReq), .memBusy(memBusy), .memAck(memAck),
      .memData(memData), .memReq(memReqV[2]), .memAddr(memAddrV[2]),
      .coreStall(coreStallV[2]), .halt(haltV[2]), .firstWord(firstWordV[2]),
      .cycleCnt(cntS), .timeout(timeoutV[2])
   );

   always_comb begin
      cntV[0] = longint'(cntA);
      cntV[1] = longint'(cntW);
      cntV[2] = longint'(cntS);
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Model: the halt sequence as three milestones (stalled, requesting, halted)
   // plus a clock count capped at the counter's range.
   longint capV [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd15};
   longint maxV [3] = '{64'd500, 64'd20, 64'd500};
   bit          mStall [3], mReq [3], mHalt [3], mTo [3];
   longint      mCnt [3];
   logic [15:0] mFw [3];
   bit          mOn = 1'b0;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         automatic bit          st = mStall[i];
         automatic bit          rq = mReq[i];
         automatic bit          hl = mHalt[i];
         automatic bit          to = mTo[i];
         automatic longint      c  = mCnt[i];
         automatic logic [15:0] f  = mFw[i];
         automatic bit          take = rq && memAck;
         if (rst) begin
            st = 0; rq = 0; hl = 0; to = 0; c = 0; f = 16'h0000;
         end else begin
            if (!hl && !take) begin
               if (maxV[i] != 0 && c == maxV[i]) to = 1;
               if (c < capV[i]) c = c + 1;
            end
            if (take) begin
               f = memData; hl = 1; rq = 0;
            end else if (st && !hl && !rq) begin
               if (!memBusy) rq = 1;
            end else if (!st && haltReq) begin
               st = 1;
            end
         end
         mStall[i] <= st;
         mReq[i]   <= rq;
         mHalt[i]  <= hl;
         mTo[i]    <= to;
         mCnt[i]   <= c;
         mFw[i]    <= f;
      end
      if (rst) mOn <= 1'b1;
   end

   always @(negedge clk) begin
      if (mOn) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("memReq[%0d]", i), longint'(memReqV[i]), longint'(mReq[i]));
            chk($sformatf("memAddr[%0d]", i), longint'(memAddrV[i]), 64'h0);
            chk($sformatf("coreStall[%0d]", i), longint'(coreStallV[i]), longint'(mStall[i]));
            chk($sformatf("halt[%0d]", i), longint'(haltV[i]), longint'(mHalt[i]));
            chk($sformatf("firstWord[%0d]", i), longint'(firstWordV[i]), longint'(mFw[i]));
            chk($sformatf("cycleCnt[%0d]", i), cntV[i], mCnt[i]);
            chk($sformatf("timeout[%0d]", i), longint'(timeoutV[i]), longint'(mTo[i]));
         end
      end
   end

   task automatic doReset();
      @(negedge clk);
      rst = 1'b1; haltReq = 1'b0; memBusy = 1'b0; memAck = 1'b0; memData = 16'h0000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic waitCyc(input int k);
      int guard = 0;
      while (cyc < k && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 1000) chk("waitCyc bound", longint'(cyc), longint'(k));
   endtask

   initial begin
      // basic halt with ack already waiting
      doReset();
      chk("reset halt", haltV[0], 0);
      chk("reset memReq", memReqV[0], 0);
      chk("reset stall", coreStallV[0], 0);
      chk("reset cnt", cntA, 0);
      chk("reset fw", firstWordV[0], 0);
      memAck = 1'b1; memData = 16'hBEEF;
      waitCyc(10); haltReq = 1'b1;
      waitCyc(11); chk("basic stall@11", coreStallV[0], 1); chk("basic req@11", memReqV[0], 0);
      waitCyc(12); chk("basic req@12", memReqV[0], 1); chk("basic halt@12", haltV[0], 0);
      waitCyc(13); chk("basic halt@13", haltV[0], 1); chk("basic fw@13", firstWordV[0], 16'hBEEF);
      chk("basic cnt@13", cntA, 12);
      waitCyc(18); chk("basic halt@18", haltV[0], 1); chk("basic fw@18", firstWordV[0], 16'hBEEF);
      chk("basic cnt@18", cntA, 12);

      // drain: busy for three cycles after haltReq
      doReset();
      waitCyc(10); haltReq = 1'b1; memBusy = 1'b1; memAck = 1'b1; memData = 16'hC0DE;
      waitCyc(14); chk("drain req@14", memReqV[0], 0); memBusy = 1'b0;
      waitCyc(15); chk("drain req@15", memReqV[0], 1); chk("drain halt@15", haltV[0], 0);
      waitCyc(16); chk("drain halt@16", haltV[0], 1); chk("drain fw@16", firstWordV[0], 16'hC0DE);

      // delayed ack, toggling data, second haltReq in READ, late extra ack
      doReset();
      waitCyc(10); haltReq = 1'b1;
      waitCyc(11); haltReq = 1'b0;
      for (int k = 11; k <= 22; k++) begin
         waitCyc(k);
         if (k >= 12 && k <= 16) begin
            chk("wait req", memReqV[0], 1);
            chk("wait addr", memAddrV[0], 16'h0000);
            chk("wait halt", haltV[0], 0);
         end
         if (k == 17) begin
            chk("wait halt@17", haltV[0], 1);
            chk("wait fw@17", firstWordV[0], 16'hA010);
         end
         memData = 16'hA000 + 16'(k);
         haltReq = (k == 14);
         memAck  = (k == 16) || (k == 20);
      end
      chk("wait fw@22", firstWordV[0], 16'hA010);

      // watchdog and saturation, no halt
      doReset();
      waitCyc(20); chk("wd tmo@20", timeoutV[1], 0); chk("sat cnt@20", cntS, 15);
      waitCyc(21); chk("wd tmo@21", timeoutV[1], 1); chk("wd halt@21", haltV[1], 0);
      waitCyc(30); chk("wd tmo@30", timeoutV[1], 1); chk("wd cnt@30", cntW, 30);
      chk("sat cnt@30", cntS, 15); chk("default tmo@30", timeoutV[0], 0);

      // reset while READ waits for an ack
      doReset();
      waitCyc(10); haltReq = 1'b1;
      waitCyc(11); haltReq = 1'b0;
      waitCyc(13); chk("rst req@13", memReqV[0], 1); rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; memAck = 1'b1; memData = 16'hDEAD;
      chk("rst req", memReqV[0], 0); chk("rst stall", coreStallV[0], 0); chk("rst cnt", cntA, 0);
      waitCyc(4); chk("rst halt@4", haltV[0], 0); chk("rst fw@4", firstWordV[0], 0);
      memAck = 1'b0;
      waitCyc(5); haltReq = 1'b1; memAck = 1'b1; memData = 16'h5A5A;
      waitCyc(8); chk("rehalt halt@8", haltV[0], 1); chk("rehalt fw@8", firstWordV[0], 16'h5A5A);
      chk("rehalt cnt@8", cntA, 7);

      // halt entered on the edge the watchdog would fire
      doReset();
      memAck = 1'b1; memData = 16'h1234;
      waitCyc(18); haltReq = 1'b1;
      waitCyc(25); chk("race halt", haltV[1], 1); chk("race tmo", timeoutV[1], 0);
      chk("race cnt", cntW, 20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      bad++;
      $display("FAIL global time limit reached at cyc %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
